// File: rtl/sp_unit_config.sv
// Shared types for the SP ACP transfer path: command word, scheduler states, length codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sp_unit_config;

    // ACP RAM line address width (16-byte lines) carried inside the command word.
    localparam int SP_ACPRAM_ADDR_WIDTH = 28;

    // Engine length encoding.
    localparam logic ACP_LEN_1BEAT = 1'b0;
    localparam logic ACP_LEN_4BEAT = 1'b1;

    // One transfer request: direction, ACP RAM line, AXI byte address, beat count.
    typedef struct packed {
        logic                            write;
        logic [SP_ACPRAM_ADDR_WIDTH-1:0] acpram_addr;
        logic [31:0]                     axi_addr;
        logic                            len;
    } acp_xfer_cmd_t;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_ACK,
        SCHED_RUN
    } sched_state_t;

endpackage

// File: rtl/sp_acp_cmd_fifo.sv
// Per-requester command queue: synchronous FIFO of acp_xfer_cmd_t, DEPTH entries.
// Latency: a push at edge t is visible on head/empty from cycle t+1; no bypass.
// Backpressure: push is ignored while full (even with a simultaneous pop); pop ignored while empty.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset (flushes the queue)
//   push, push_cmd enqueue request and its command
//   pop            dequeue the head
//   full, empty    occupancy flags, derived from registered pointers only
//   head           oldest entry (undefined content while empty)
module sp_acp_cmd_fifo
    import sp_unit_config::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  acp_xfer_cmd_t push_cmd,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output acp_xfer_cmd_t head
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the index bits match.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    acp_xfer_cmd_t mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_cmd;
        end
    end

endmodule

// File: rtl/sp_acp_xfer_sched.sv
// Round-robin scheduler of ACP RAM <-> AXI transfer commands onto the single acpram_axi engine.
// Latency: push to engine start pulse >= 2 cycles; done/err pulse 1 cycle after engine busy falls / ack timeout.
// Backpressure: req_ready[i] = queue i not full; one transfer in flight at a time, next grant after done/err.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       per-requester command handshake (push on valid & ready)
//   req_cmd                   per-requester command word
//   req_done/req_err          one-cycle completion / no-acknowledge pulse to the owning requester
//   sched_busy                registered: a queue holds work or a transfer is in flight
//   eng_read/eng_write        one-cycle engine start pulses
//   eng_acpram_addr/axi_addr/len  transfer parameters, held from start until the next grant
//   eng_busy                  engine busy flag
module sp_acp_xfer_sched
    import sp_unit_config::*;
#(
    parameter int NREQ              = 2,
    parameter int DEPTH             = 4,
    // Must equal SP_ACPRAM_ADDR_WIDTH: the command word carries that many address bits.
    parameter int ACPRAM_ADDR_WIDTH = SP_ACPRAM_ADDR_WIDTH,
    parameter int ACK_TIMEOUT       = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  acp_xfer_cmd_t [NREQ-1:0]     req_cmd,
    output logic [NREQ-1:0]              req_done,
    output logic [NREQ-1:0]              req_err,
    output logic                         sched_busy,
    output logic                         eng_read,
    output logic                         eng_write,
    output logic [ACPRAM_ADDR_WIDTH-1:0] eng_acpram_addr,
    output logic [31:0]                  eng_axi_addr,
    output logic                         eng_len,
    input  logic                         eng_busy
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic [NREQ-1:0] full;
    logic [NREQ-1:0] empty;
    logic [NREQ-1:0] pop;
    acp_xfer_cmd_t   heads [NREQ];

    sched_state_t    state;
    sched_state_t    state_nxt;
    // last_grant doubles as the owner of the transfer in flight.
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   pick;
    logic            any_pend;
    logic            start;
    acp_xfer_cmd_t   sel_cmd;
    logic [CW-1:0]   ack_cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [NREQ-1:0] done_nxt;
    logic [NREQ-1:0] err_nxt;

    // ------------------------------------------------------------------
    // Per-requester queues
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NREQ; g++) begin : g_q
        sp_acp_cmd_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (req_valid[g]),
            .push_cmd (req_cmd[g]),
            .pop      (pop[g]),
            .full     (full[g]),
            .empty    (empty[g]),
            .head     (heads[g])
        );
    end

    assign req_ready = ~full;

    // ------------------------------------------------------------------
    // Round-robin pick: first non-empty queue after last_grant.
    // Scanning offsets from far to near lets the nearest one win.
    // ------------------------------------------------------------------
    always_comb begin
        any_pend = 1'b0;
        pick     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (!empty[GW'((int'(last_grant) + k) % NREQ)]) begin
                pick     = GW'((int'(last_grant) + k) % NREQ);
                any_pend = 1'b1;
            end
        end
    end

    assign sel_cmd = heads[pick];

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pop       = '0;
        start     = 1'b0;
        cnt_nxt   = ack_cnt;
        done_nxt  = '0;
        err_nxt   = '0;
        case (state)
            SCHED_IDLE: begin
                if (any_pend) begin
                    pop[pick] = 1'b1;
                    start     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SCHED_ACK;
                end
            end
            SCHED_ACK: begin
                if (eng_busy) begin
                    state_nxt = SCHED_RUN;
                end else if (ack_cnt == CW'(ACK_TIMEOUT)) begin
                    // Engine never acknowledged: give the command back as an error.
                    err_nxt[last_grant] = 1'b1;
                    state_nxt           = SCHED_IDLE;
                end else begin
                    cnt_nxt = ack_cnt + 1'b1;
                end
            end
            SCHED_RUN: begin
                if (!eng_busy) begin
                    done_nxt[last_grant] = 1'b1;
                    state_nxt            = SCHED_IDLE;
                end
            end
            default: begin
                state_nxt = SCHED_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= SCHED_IDLE;
            last_grant      <= GW'(NREQ - 1);
            ack_cnt         <= '0;
            req_done        <= '0;
            req_err         <= '0;
            eng_read        <= 1'b0;
            eng_write       <= 1'b0;
            eng_acpram_addr <= '0;
            eng_axi_addr    <= '0;
            eng_len         <= ACP_LEN_1BEAT;
            sched_busy      <= 1'b0;
        end else begin
            state      <= state_nxt;
            ack_cnt    <= cnt_nxt;
            req_done   <= done_nxt;
            req_err    <= err_nxt;
            eng_read   <= start & ~sel_cmd.write;
            eng_write  <= start & sel_cmd.write;
            sched_busy <= (state != SCHED_IDLE) | ~(&empty);
            // Transfer parameters only change on a new grant so the engine may sample them late.
            if (start) begin
                last_grant      <= pick;
                eng_acpram_addr <= sel_cmd.acpram_addr;
                eng_axi_addr    <= sel_cmd.axi_addr;
                eng_len         <= sel_cmd.len;
            end
        end
    end

endmodule

// File: tb/tb_sp_acp_xfer_sched.sv
module tb_sp_acp_xfer_sched;
    import sp_unit_config::*;

    localparam int NREQ     = 2;
    localparam int DEPTH    = 4;
    localparam int AW       = 28;
    localparam int TMO      = 15;
    localparam int BUSY_LEN = 5;

    typedef struct {
        int port;
        bit err;
    } done_exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_ready;
    acp_xfer_cmd_t [NREQ-1:0] req_cmd = '0;
    logic [NREQ-1:0]        req_done;
    logic [NREQ-1:0]        req_err;
    logic                   sched_busy;
    logic                   eng_read;
    logic                   eng_write;
    logic [AW-1:0]          eng_acpram_addr;
    logic [31:0]            eng_axi_addr;
    logic                   eng_len;
    logic                   eng_busy;

    sp_acp_xfer_sched #(
        .NREQ              (NREQ),
        .DEPTH             (DEPTH),
        .ACPRAM_ADDR_WIDTH (AW),
        .ACK_TIMEOUT       (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_cmd         (req_cmd),
        .req_done        (req_done),
        .req_err         (req_err),
        .sched_busy      (sched_busy),
        .eng_read        (eng_read),
        .eng_write       (eng_write),
        .eng_acpram_addr (eng_acpram_addr),
        .eng_axi_addr    (eng_axi_addr),
        .eng_len         (eng_len),
        .eng_busy        (eng_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    acp_xfer_cmd_t exp_start[$];
    done_exp_t     exp_done[$];
    int            checks = 0;
    int            errors = 0;
    int            last_start_cyc = -100;
    int            fall_cyc = -100;
    int            push_cyc = 0;
    acp_xfer_cmd_t last_cmd = '0;
    acp_xfer_cmd_t mon_e;
    done_exp_t     mon_d;
    bit            tie0 = 1'b0;
    bit            hold_busy = 1'b0;
    int            eng_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic acp_xfer_cmd_t mk(input bit w, input logic [AW-1:0] a,
                                         input logic [31:0] x, input bit l);
        acp_xfer_cmd_t c;
        c.write       = w;
        c.acpram_addr = a;
        c.axi_addr    = x;
        c.len         = l;
        return c;
    endfunction

    function automatic done_exp_t de(input int p, input bit e);
        done_exp_t d;
        d.port = p;
        d.err  = e;
        return d;
    endfunction

    // Engine model: busy rises the cycle after a start pulse and lasts BUSY_LEN cycles
    // (longer while hold_busy); with tie0 the engine never acknowledges.
    initial begin
        eng_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && (eng_read || eng_write) && !tie0) begin
                @(posedge clk);
                #1 eng_busy = 1'b1;
                eng_n = 0;
                while (hold_busy || eng_n < BUSY_LEN) begin
                    @(posedge clk);
                    eng_n++;
                end
                #1 eng_busy = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    // Monitor: compares every start pulse and every done/err pulse against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (eng_read || eng_write) begin
                chk("start_exclusive", 64'(eng_read & eng_write), 64'd0);
                chk("start_expected", 64'(exp_start.size() != 0), 64'd1);
                if (exp_start.size() != 0) begin
                    mon_e = exp_start.pop_front();
                    chk("start_write", 64'(eng_write), 64'(mon_e.write));
                    chk("start_read", 64'(eng_read), 64'(!mon_e.write));
                    chk("start_acpram_addr", 64'(eng_acpram_addr), 64'(mon_e.acpram_addr));
                    chk("start_axi_addr", 64'(eng_axi_addr), 64'(mon_e.axi_addr));
                    chk("start_len", 64'(eng_len), 64'(mon_e.len));
                    last_cmd = mon_e;
                end
                last_start_cyc = cyc;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_done[i] || req_err[i]) begin
                    chk("done_err_exclusive", 64'(req_done[i] & req_err[i]), 64'd0);
                    chk("done_expected", 64'(exp_done.size() != 0), 64'd1);
                    if (exp_done.size() != 0) begin
                        mon_d = exp_done.pop_front();
                        chk("done_port", 64'(i), 64'(mon_d.port));
                        chk("done_is_err", 64'(req_err[i]), 64'(mon_d.err));
                        if (req_err[i]) begin
                            chk("err_latency", 64'(cyc - last_start_cyc), 64'(TMO + 1));
                        end else begin
                            chk("done_latency", 64'(cyc - fall_cyc), 64'd1);
                            chk("held_len", 64'(eng_len), 64'(last_cmd.len));
                            chk("held_axi_addr", 64'(eng_axi_addr), 64'(last_cmd.axi_addr));
                            chk("held_acpram_addr", 64'(eng_acpram_addr), 64'(last_cmd.acpram_addr));
                        end
                    end
                end
            end
        end
    end

    // Present commands on the ports in mask m; wait (bounded) until all are ready; push on one edge.
    task automatic push(input logic [NREQ-1:0] m, input acp_xfer_cmd_t c0, input acp_xfer_cmd_t c1);
        int n = 0;
        @(negedge clk);
        req_cmd[0] = c0;
        req_cmd[1] = c1;
        req_valid  = m;
        while (((req_ready & m) != m) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready_wait", 64'(n < 200), 64'd1);
        @(posedge clk);
        #1;
        push_cyc  = cyc;
        req_valid = '0;
    endtask

    task automatic wait_start(input string name, input int budget);
        int n = 0;
        while (exp_start.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_start_in_time"}, 64'(n < budget), 64'd1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_start.size() != 0 || exp_done.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_in_time"}, 64'(n < budget), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_req_ready"}, 64'(req_ready), 64'(2'b11));
        chk({name, "_sched_busy"}, 64'(sched_busy), 64'd0);
        chk({name, "_eng_read"}, 64'(eng_read), 64'd0);
        chk({name, "_eng_write"}, 64'(eng_write), 64'd0);
        chk({name, "_eng_acpram_addr"}, 64'(eng_acpram_addr), 64'd0);
        chk({name, "_eng_axi_addr"}, 64'(eng_axi_addr), 64'd0);
        chk({name, "_eng_len"}, 64'(eng_len), 64'd0);
        chk({name, "_req_done"}, 64'(req_done), 64'd0);
        chk({name, "_req_err"}, 64'(req_err), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected end before limit", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        acp_xfer_cmd_t a0, a1, a2, b0, b1, b2, c;

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b0;

        // ---------------- round robin: both push 3 in the same cycles ----------------
        a0 = mk(1'b0, 28'h100, 32'h4000_0000, ACP_LEN_1BEAT);
        a1 = mk(1'b1, 28'h101, 32'h4000_0010, ACP_LEN_4BEAT);
        a2 = mk(1'b0, 28'h102, 32'h4000_0020, ACP_LEN_4BEAT);
        b0 = mk(1'b1, 28'h200, 32'h5000_0000, ACP_LEN_4BEAT);
        b1 = mk(1'b0, 28'h201, 32'h5000_0100, ACP_LEN_1BEAT);
        b2 = mk(1'b1, 28'h202, 32'h5000_0200, ACP_LEN_1BEAT);
        exp_start.push_back(a0); exp_start.push_back(b0);
        exp_start.push_back(a1); exp_start.push_back(b1);
        exp_start.push_back(a2); exp_start.push_back(b2);
        for (int k = 0; k < 6; k++) exp_done.push_back(de(k % 2, 1'b0));
        push(2'b11, a0, b0);
        push(2'b11, a1, b1);
        push(2'b11, a2, b2);
        wait_drain("rr", 400);

        // ---------------- single 1-beat read ----------------
        c = mk(1'b0, 28'h10, 32'h8000_0000, ACP_LEN_1BEAT);
        exp_start.push_back(c);
        exp_done.push_back(de(0, 1'b0));
        push(2'b01, c, '0);
        wait_start("rd1", 20);
        // Push sampled at edge k; start pulse visible after edge k+1.
        chk("rd1_push_to_pulse", 64'(last_start_cyc - push_cyc), 64'd1);
        wait_drain("rd1", 60);

        // ---------------- 4-beat write ----------------
        c = mk(1'b1, 28'h3, 32'h1000_0040, ACP_LEN_4BEAT);
        exp_start.push_back(c);
        exp_done.push_back(de(1, 1'b0));
        push(2'b10, '0, c);
        wait_start("wr4", 20);
        repeat (3) @(negedge clk);
        chk("wr4_len_held_mid", 64'(eng_len), 64'd1);
        chk("wr4_pulse_single", 64'(eng_write), 64'd0);
        wait_drain("wr4", 60);

        // ---------------- full queue with a transfer parked in RUN ----------------
        hold_busy = 1'b1;
        c = mk(1'b0, 28'h77, 32'h2000_0000, ACP_LEN_1BEAT);
        exp_start.push_back(c);
        exp_done.push_back(de(1, 1'b0));
        push(2'b10, '0, c);
        wait_start("fullA", 20);
        for (int k = 0; k < 5; k++) begin
            exp_start.push_back(mk(1'b0, 28'(28'h300 + k), 32'h3000_0000 + 32'(k * 16), ACP_LEN_1BEAT));
            exp_done.push_back(de(0, 1'b0));
        end
        for (int k = 0; k < 4; k++) begin
            push(2'b01, mk(1'b0, 28'(28'h300 + k), 32'h3000_0000 + 32'(k * 16), ACP_LEN_1BEAT), '0);
        end
        @(negedge clk);
        chk("full_ready_low", 64'(req_ready[0]), 64'd0);
        chk("full_other_ready", 64'(req_ready[1]), 64'd1);
        chk("full_sched_busy", 64'(sched_busy), 64'd1);
        fork
            push(2'b01, mk(1'b0, 28'h304, 32'h3000_0040, ACP_LEN_1BEAT), '0);
            begin
                repeat (8) @(negedge clk);
                chk("full_still_blocked", 64'(req_ready[0]), 64'd0);
                hold_busy = 1'b0;
            end
        join
        wait_drain("full", 400);

        // ---------------- ack timeout, then the next queued command ----------------
        tie0 = 1'b1;
        c = mk(1'b0, 28'h55, 32'h6000_0000, ACP_LEN_1BEAT);
        exp_start.push_back(c);
        exp_done.push_back(de(0, 1'b1));
        exp_start.push_back(mk(1'b1, 28'h56, 32'h6000_0010, ACP_LEN_4BEAT));
        exp_done.push_back(de(0, 1'b1));
        push(2'b01, c, '0);
        push(2'b01, mk(1'b1, 28'h56, 32'h6000_0010, ACP_LEN_4BEAT), '0);
        wait_drain("tmo", 200);
        tie0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("tmo_idle_sched_busy", 64'(sched_busy), 64'd0);

        // ---------------- reset during RUN with commands queued ----------------
        hold_busy = 1'b1;
        c = mk(1'b0, 28'h88, 32'h7000_0000, ACP_LEN_4BEAT);
        exp_start.push_back(c);
        push(2'b01, c, '0);
        wait_start("rstrun", 20);
        push(2'b11, mk(1'b1, 28'h89, 32'h7000_0010, ACP_LEN_1BEAT),
                    mk(1'b0, 28'h8a, 32'h7000_0020, ACP_LEN_1BEAT));
        repeat (3) @(negedge clk);
        chk("rstrun_busy_before", 64'(sched_busy), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rstrun");
        hold_busy = 1'b0;
        repeat (40) @(negedge clk);
        chk("rstrun_quiet_busy", 64'(sched_busy), 64'd0);

        // ---------------- end ----------------
        chk("end_starts_consumed", 64'(exp_start.size()), 64'd0);
        chk("end_dones_consumed", 64'(exp_done.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sp_acp_xfer_sched.md
Name: sp_acp_xfer_sched

Overview:
- Schedules ACP transfer commands (ACP RAM <-> AXI, 1 or 4 beats) from several requesters onto the single acpram_axi engine.
- Typical requesters: the SP ACP command unit and a hardware descriptor/prefetch agent.
- Each requester has its own command queue; queues are served round-robin.
- Drives the engine's one-cycle read/write start pulses and tracks completion through the engine busy flag.
- Returns a one-cycle done (or error) pulse to the owning requester.

Parameters:
- NREQ, 2, number of requester ports (2..4).
- DEPTH, 4, entries per requester queue; power of two, >= 2.
- ACPRAM_ADDR_WIDTH, 28, ACP RAM line address width (16-byte lines).
- ACK_TIMEOUT, 15, cycles to wait for engine busy to rise before flagging an error.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester queue not full.
- req_cmd  in  NREQ x $bits(acp_xfer_cmd_t)  command {write, acpram_addr, axi_addr[31:0], len}.
- req_done  out  NREQ  one-cycle pulse: the requester's oldest issued command completed.
- req_err  out  NREQ  one-cycle pulse: the requester's command got no engine acknowledge.
- sched_busy  out  1  any queue non-empty or a transfer in flight.
- eng_read  out  1  engine read-start pulse.
- eng_write  out  1  engine write-start pulse.
- eng_acpram_addr  out  ACPRAM_ADDR_WIDTH  engine ACP RAM line address.
- eng_axi_addr  out  32  engine AXI byte address.
- eng_len  out  1  engine length: 0 = 1 beat, 1 = 4 beats.
- eng_busy  in  1  engine busy flag.

Behaviour:
- Reset values: req_done=0, req_err=0, eng_read=0, eng_write=0, eng_* address/len=0, sched_busy=0, all queues empty, state IDLE, last_grant=NREQ-1 (requester 0 wins first).
- req_ready[i] is the registered inverse of queue full. A push occurs on valid & ready. There is no push while full, even if a pop happens in the same cycle.
- Queue order is FIFO per requester. A push at edge t is visible (eligible) from cycle t+1. There is no bypass path.
- States IDLE, ACK, RUN.
- IDLE: if any queue is non-empty, grant the first non-empty queue scanning from last_grant+1 (mod NREQ).
  - Pop its head, register the command onto eng_*, and pulse eng_read or eng_write (selected by cmd.write) for exactly one cycle.
  - Update last_grant, clear ack_cnt, go to ACK.
  - Minimum push-to-pulse latency is 2 cycles.
- ACK:
  - eng_busy=1 -> go to RUN.
  - Otherwise ack_cnt++. When ack_cnt reaches ACK_TIMEOUT, pulse req_err[grant] and go to IDLE.
- RUN: eng_busy=0 -> pulse req_done[grant] for one cycle and go to IDLE.
- Back-to-back: the next grant can be decided in the cycle after the done pulse, so there is at least one idle cycle between transfers.
- eng_acpram_addr, eng_axi_addr and eng_len are held stable from the start pulse until the next grant.
- eng_read and eng_write are never high together, and never high outside IDLE->ACK transitions.
- sched_busy = (state != IDLE) | any queue non-empty; registered.
- Simultaneous push to a queue and pop from the same queue: both take effect; count is unchanged; order is preserved.
- Pointer wrap: pointers are log2(DEPTH)+1 bits wide; full/empty is decided by MSB compare.
- Reset mid-transfer: queues are flushed and the state returns to IDLE. No done/err is emitted for the lost command. The engine is not aborted; it is reset by its own reset.

Decomposition:
- Package sp_unit_config (shared):
  - acp_xfer_cmd_t packed struct {logic write; logic [ACPRAM_ADDR_WIDTH-1:0] acpram_addr; logic [31:0] axi_addr; logic len;}
  - sched state enum {SCHED_IDLE, SCHED_ACK, SCHED_RUN}
  - ACP_LEN_1BEAT=1'b0 and ACP_LEN_4BEAT=1'b1
- Sub-module sp_acp_cmd_fifo: one per requester. Synchronous FIFO of acp_xfer_cmd_t, DEPTH entries, with ports push/pop/full/empty/head.
- Arbitration and the FSM live in the top module.

Test Plan:
- Single read, 1 beat: req0 cmd {write=0, acpram_addr=0x10, axi_addr=0x8000_0000, len=0}; engine busy rises the cycle after the pulse and lasts 5 cycles.
  -> eng_read pulses once, 2 cycles after the push, with the command values on eng_*; eng_write stays 0; req_done[0] pulses 1 cycle after busy falls.
- Round-robin: req0 and req1 each push 3 commands in the same cycle.
  -> engine start order is r0,r1,r0,r1,r0,r1; 6 done pulses land on the matching ports.
- Full queue: req0 pushes 5 commands with no engine progress (busy held high).
  -> req_ready[0] drops after the 4th push while 1 command is in flight; the 5th is accepted only after a pop; no command is lost or duplicated.
- Ack timeout: eng_busy tied 0.
  -> req_err[grant] pulses exactly ACK_TIMEOUT+1 cycles after the start pulse; no req_done; the next queued command issues afterwards.
- Write, 4 beats: {write=1, acpram_addr=0x3, axi_addr=0x1000_0040, len=1}.
  -> eng_write pulses; eng_len=1 is held until done.
- Reset during RUN: assert rst with 2 commands queued.
  -> the cycle after reset, all outputs are at reset values, req_ready is all 1, sched_busy=0, and no done/err pulse appears.
